sat_accumulator: RTL

- Streaming saturating accumulator: sums a burst of WIDTH-bit operands into one clamped result.
- Clamping is applied after every beat, so intermediate overflow never wraps.
- Signed or unsigned mode is selected per burst; sticky overflow flags and a saturating beat count are reported with the result.
- Sits beside the ALU/CSR path for saturating reductions (checksums, counters, DSP-style extensions); valid/ready on both sides.

---
 rtl/sat_accumulator_pkg.sv | 9 +
 rtl/sat_step_adder.sv | 42 ++++
 rtl/sat_accumulator.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sat_accumulator_pkg.sv
// Shared definitions for the saturating accumulator: FSM state encodings.
// Width-dependent clamp limits live in sat_step_adder, where WIDTH is known.
package sat_acc_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sat_step_adder.sv
// One accumulation step: WIDTH-bit add of a and b with signed/unsigned overflow
// detection, clamped to the range limit unless wrap is set.
module sat_step_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sig,
    input  logic             wrap,
    output logic [WIDTH-1:0] sum,
    output logic             po,
    output logic             no
);

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] UNS_MAX = {WIDTH{1'b1}};

    logic [WIDTH:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};

    always_comb begin
        if (sig) begin
            po = !a[WIDTH-1] && !b[WIDTH-1] &&  raw[WIDTH-1];
            no =  a[WIDTH-1] &&  b[WIDTH-1] && !raw[WIDTH-1];
        end else begin
            po = raw[WIDTH];
            no = 1'b0;
        end
        sum = raw[WIDTH-1:0];
        // Flags are reported even in wrap mode; only the clamp is suppressed.
        if (!wrap) begin
            if (po) begin
                sum = sig ? POS_MAX : UNS_MAX;
            end else if (no) begin
                sum = NEG_MAX;
            end
        end
    end

endmodule

// File: rtl/sat_accumulator.sv
// Streaming saturating accumulator with valid/ready on both sides.
// Optional macro SAT_ACC_WRAP_MODE_EN adds in_wrap for per-burst modular addition.
module sat_accumulator
    import sat_acc_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sig,
`ifdef SAT_ACC_WRAP_MODE_EN
    input  logic             in_wrap,
`endif
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_po,
    output logic             out_no,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] acc_reg;
    logic             po_reg, no_reg, sig_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             accept, first_beat;
    logic [WIDTH-1:0] step_a, step_sum;
    logic             step_sig, step_wrap, step_po, step_no;

    assign in_ready   = (state_reg != ST_DONE) || out_ready;
    assign accept     = in_valid && in_ready;
    // Any beat accepted outside ACC opens a new burst (IDLE, or DONE on the pop cycle).
    assign first_beat = (state_reg != ST_ACC);

    assign step_a   = first_beat ? '0 : acc_reg;
    assign step_sig = first_beat ? in_sig : sig_reg;

`ifdef SAT_ACC_WRAP_MODE_EN
    logic wrap_reg;
    assign step_wrap = first_beat ? in_wrap : wrap_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_reg <= 1'b0;
        end else if (accept) begin
            wrap_reg <= step_wrap;
        end
    end
`else
    assign step_wrap = 1'b0;
`endif

    sat_step_adder #(.WIDTH(WIDTH)) u_step (
        .a    (step_a),
        .b    (in_data),
        .sig  (step_sig),
        .wrap (step_wrap),
        .sum  (step_sum),
        .po   (step_po),
        .no   (step_no)
    );

    always_comb begin
        if (first_beat) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    state_next = in_last ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_next = in_last ? ST_DONE : ST_ACC;
                end else if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            po_reg    <= 1'b0;
            no_reg    <= 1'b0;
            cnt_reg   <= '0;
            sig_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                acc_reg <= step_sum;
                po_reg  <= step_po || (!first_beat && po_reg);
                no_reg  <= step_no || (!first_beat && no_reg);
                cnt_reg <= cnt_next;
                sig_reg <= step_sig;
            end
        end
    end

    assign out_valid = (state_reg == ST_DONE);
    assign out_data  = acc_reg;
    assign out_po    = po_reg;
    assign out_no    = no_reg;
    assign out_cnt   = cnt_reg;

endmodule
